// File: rtl/rca_seq_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder sequencer: slice width,
// FSM state encoding and the slice index width helper.
package rca_seq_adder_ctrl_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index must address WIDTH/SLICE_W slices; keep at least one bit.
  function automatic int idx_width(input int width);
    int n;
    n = width / SLICE_W;
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rca_seq_adder_ctrl_ripple_carry_adder.sv
// Combinational W-bit ripple-carry adder slice built from full-adder cells.
module ripple_carry_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[W];

endmodule

// File: rtl/rca_seq_adder_ctrl.sv
// Multi-cycle WIDTH-bit adder: one shared 4-bit ripple slice, one nibble per
// clock, LSB first. Define RCA_SUB_EN to add the sub port (a - b).
module rca_seq_adder_ctrl
  import rca_seq_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef RCA_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int N  = WIDTH / SLICE_W;
  localparam int IW = idx_width(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t             state, state_nx;
  logic               load;
  logic [IW-1:0]      idx;
  logic               carry;
  logic               carry_init;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [SLICE_W-1:0] slice_a, slice_b, slice_s;
  logic               slice_co;

  assign slice_a = a_q[SLICE_W*idx +: SLICE_W];

`ifdef RCA_SUB_EN
  logic sub_q;

  // Subtract as a + ~b + 1: invert each B nibble and force the first carry.
  assign slice_b    = b_q[SLICE_W*idx +: SLICE_W] ^ {SLICE_W{sub_q}};
  assign carry_init = sub | cin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    sub_q <= 1'b0;
    else if (load) sub_q <= sub;
  end
`else
  assign slice_b    = b_q[SLICE_W*idx +: SLICE_W];
  assign carry_init = cin;
`endif

  ripple_carry_adder #(.W(SLICE_W)) u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry),
    .s    (slice_s),
    .cout (slice_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Start is only honoured from IDLE or DONE, so DONE can chain straight into RUN.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        state_nx = RUN;
        load     = 1'b1;
      end
      RUN:  if (idx == LAST) state_nx = DONE;
      DONE: if (start) begin
        state_nx = RUN;
        load     = 1'b1;
      end else begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      idx   <= '0;
      carry <= 1'b0;
      s     <= '0;
      cout  <= 1'b0;
    end else if (load) begin
      a_q   <= a;
      b_q   <= b;
      idx   <= '0;
      carry <= carry_init;
    end else if (state == RUN) begin
      s[SLICE_W*idx +: SLICE_W] <= slice_s;
      carry                     <= slice_co;
      idx                       <= (idx == LAST) ? '0 : idx + IW'(1);
      if (idx == LAST) cout <= slice_co;
    end
  end

endmodule
